// File: rtl/spram_pkg.sv
// Shared definitions for the single-port RAM burst sequencer and its RAM primitive.
package spram_pkg;

  localparam int unsigned DefaultWidth = 16;
  localparam int unsigned DefaultDepth = 8;

  typedef enum logic [2:0] {
    StIdle,
    StFill,
    StRead,
    StWait,
    StPresent
  } spram_state_t;

endpackage

// File: rtl/single_port_ram.sv
// Single-port RAM primitive: synchronous write, registered read data.
module single_port_ram #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             we,
  input  logic [DEPTH-1:0] addr,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] mem [2**DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= data;
    end
    q <= mem[addr];
  end

endmodule

// File: rtl/spram_burst_ctrl.sv
// Stores an input burst into consecutive RAM words from address 0, then replays it in order
// on the output stream. Owns the single RAM port, so reads and writes never overlap.
module spram_burst_ctrl
  import spram_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  parameter int unsigned DEPTH = DefaultDepth
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             ram_we,
  output logic [DEPTH-1:0] ram_addr,
  output logic [WIDTH-1:0] ram_data,
  input  logic [WIDTH-1:0] ram_q,
  output logic [DEPTH:0]   burst_len,
  output logic             busy
);

  localparam logic [DEPTH-1:0] PtrOne = DEPTH'(1);
  localparam logic [DEPTH-1:0] PtrMax = '1;
  localparam logic [DEPTH:0]   LenOne = (DEPTH + 1)'(1);

  spram_state_t     state_q, state_d;
  logic [DEPTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH:0]   burst_len_q, burst_len_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_last_q, out_last_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      burst_len_q <= '0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      burst_len_q <= burst_len_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    burst_len_d = burst_len_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    in_ready    = 1'b0;
    ram_addr    = rd_ptr_q;

    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        ram_addr = '0;
        if (in_valid) begin
          wr_ptr_d    = PtrOne;
          burst_len_d = LenOne;
          state_d     = in_last ? StRead : StFill;
        end
      end
      StFill: begin
        in_ready = 1'b1;
        ram_addr = wr_ptr_q;
        if (in_valid) begin
          wr_ptr_d    = wr_ptr_q + PtrOne;
          burst_len_d = burst_len_q + LenOne;
          // Writing the top address fills the RAM and ends the burst regardless of in_last.
          if (in_last || (wr_ptr_q == PtrMax)) begin
            state_d = StRead;
          end
        end
      end
      StRead: begin
        state_d = StWait;
      end
      StWait: begin
        out_data_d = ram_q;
        out_last_d = ({1'b0, rd_ptr_q} == (burst_len_q - LenOne));
        state_d    = StPresent;
      end
      StPresent: begin
        if (out_ready) begin
          if (out_last_q) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            state_d  = StIdle;
          end else begin
            rd_ptr_d = rd_ptr_q + PtrOne;
            state_d  = StRead;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign ram_we    = in_valid & in_ready;
  assign ram_data  = in_data;
  assign out_valid = (state_q == StPresent);
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign burst_len = burst_len_q;
  assign busy      = (state_q != StIdle);

endmodule
